// File: rtl/past_sequence_differencer_if.sv
// Windowed-sum in / recovered-sample out bundle for the differencer.
// Valid-only qualification in both directions; the sink never stalls.
interface past_sequence_differencer_if #(
    parameter int DW = 8
);
    logic          in_valid;
    logic [DW-1:0] inp;
    logic          out_valid;
    logic [DW-1:0] outp;
    logic          primed;

    modport master (
        output in_valid, inp,
        input  out_valid, outp, primed
    );

    modport slave (
        input  in_valid, inp,
        output out_valid, outp, primed
    );
endinterface

// File: rtl/past_sequence_differencer.sv
// Recovers x[n] = y[n] - y[n-1] + x[n-W] from a W-sample moving sum, 1-cycle latency.
// One sample per accepted cycle, no backpressure; idle gaps of any length hold state.
module past_sequence_differencer #(
    parameter int N  = 4,
    parameter int DW = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    past_sequence_differencer_if.slave  sd
);
    localparam int         W     = 1 << N;
    localparam logic [N:0] W_CNT = (N+1)'(W);

    logic [DW-1:0] hist_q [W];
    logic [N-1:0]  wp_q;
    logic [DW-1:0] prev_q;
    logic [N:0]    cnt_q;
    logic [DW-1:0] outp_q;
    logic          out_valid_q;
    logic          primed_q;

    logic [DW-1:0] x_d;
    logic [N:0]    cnt_d;

    // hist_q[wp_q] still holds x[n-W] here; it is overwritten with x[n] at the same edge.
    always_comb begin
        x_d   = sd.inp - prev_q + hist_q[wp_q];
        cnt_d = (cnt_q == W_CNT) ? cnt_q : cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < W; i++) begin
                hist_q[i] <= '0;
            end
            wp_q        <= '0;
            prev_q      <= '0;
            cnt_q       <= '0;
            outp_q      <= '0;
            out_valid_q <= 1'b0;
            primed_q    <= 1'b0;
        end else if (sd.in_valid) begin
            hist_q[wp_q] <= x_d;
            wp_q         <= wp_q + 1'b1;
            prev_q       <= sd.inp;
            cnt_q        <= cnt_d;
            outp_q       <= x_d;
            out_valid_q  <= 1'b1;
            primed_q     <= (cnt_d == W_CNT);
        end else begin
            out_valid_q <= 1'b0;
        end
    end

    assign sd.outp      = outp_q;
    assign sd.out_valid = out_valid_q;
    assign sd.primed    = primed_q;
endmodule

// File: tb/tb_past_sequence_differencer.sv
// Drives moving sums built from known raw samples and checks the recovered stream.
// Inputs change on the falling edge; outputs are sampled 1 time unit after the rising edge.
module tb_past_sequence_differencer;
    localparam int N  = 2;
    localparam int W  = 1 << N;
    localparam int DW = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_chk  = 0;
    int   n_fail = 0;

    // Reference: raw samples accepted since the last reset.
    logic [DW-1:0] xs [$];
    logic [DW-1:0] last_x;

    past_sequence_differencer_if #(.DW(DW)) bus ();

    past_sequence_differencer #(.N(N), .DW(DW)) dut (
        .clk (clk),
        .rst (rst),
        .sd  (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Moving sum the upstream summer would emit if x were accepted next.
    function automatic logic [DW-1:0] window_sum(input logic [DW-1:0] x);
        logic [DW-1:0] s;
        s = x;
        for (int i = 0; i < W - 1 && i < xs.size(); i++) begin
            s = s + xs[xs.size() - 1 - i];
        end
        return s;
    endfunction

    task automatic send_x(input logic [DW-1:0] x, input string tag);
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.inp      = window_sum(x);
        @(posedge clk);
        #1;
        xs.push_back(x);
        last_x = x;
        chk({tag, ".vld"}, 32'(bus.out_valid), 32'd1);
        chk({tag, ".outp"}, 32'(bus.outp), 32'(x));
        chk({tag, ".primed"}, 32'(bus.primed), 32'(xs.size() >= W));
    endtask

    task automatic idle(input string tag);
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.inp      = DW'($urandom);
        @(posedge clk);
        #1;
        chk({tag, ".vld"}, 32'(bus.out_valid), 32'd0);
        chk({tag, ".outp"}, 32'(bus.outp), 32'(last_x));
        chk({tag, ".primed"}, 32'(bus.primed), 32'(xs.size() >= W));
    endtask

    task automatic do_reset(input int cycles, input logic vld, input string tag);
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk);
            rst          = 1'b1;
            bus.in_valid = vld;
            bus.inp      = 8'd99;
            @(posedge clk);
            #1;
            chk({tag, ".outp"}, 32'(bus.outp), 32'd0);
            chk({tag, ".vld"}, 32'(bus.out_valid), 32'd0);
            chk({tag, ".primed"}, 32'(bus.primed), 32'd0);
        end
        @(negedge clk);
        rst          = 1'b0;
        bus.in_valid = 1'b0;
        xs.delete();
        last_x = '0;
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.inp      = '0;
        last_x       = '0;

        // Reset and idle.
        do_reset(2, 1'b0, "rst");
        for (int i = 0; i < 3; i++) idle("idle0");

        // Ramp x = 1..6 (y = 1,3,6,10,14,18).
        for (int i = 1; i <= 6; i++) send_x(DW'(i), "ramp");

        // Constant 200 wrapping mod 256 (y = 200,144,88,32,32).
        do_reset(1, 1'b0, "rst3");
        for (int i = 0; i < 5; i++) send_x(8'd200, "wrap");

        // Ramp with 3-cycle gaps.
        do_reset(1, 1'b0, "rst4");
        for (int i = 1; i <= 6; i++) begin
            send_x(DW'(i), "gap");
            for (int g = 0; g < 3; g++) idle("gapidle");
        end

        // Reset mid-stream with in_valid high; the sample under reset is dropped.
        do_reset(1, 1'b0, "rst5a");
        for (int i = 1; i <= 3; i++) send_x(DW'(i), "pre");
        do_reset(1, 1'b1, "rst5b");
        send_x(8'd7, "post");
        send_x(8'd8, "post");

        // Random samples with random gaps.
        do_reset(1, 1'b0, "rst6");
        for (int i = 0; i < 1000; i++) begin
            if ($urandom_range(0, 3) != 0) send_x(DW'($urandom), "rand");
            else                           idle("randidle");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
